// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_credit_counter.sv
// Saturating up/down counter; increment and decrement may occur in the same cycle
// and the net change is applied at once. o_next exposes the post-update value.
module fetch_credit_counter #(
  parameter int unsigned MaxVal   = 8,
  parameter int unsigned ResetVal = 8,
  parameter int unsigned Width    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_inc,
  input  logic             i_dec,
  output logic [Width-1:0] o_count,
  output logic [Width-1:0] o_next
);

  logic [Width-1:0] r_count;
  logic [Width-1:0] w_count_next;
  int               w_sum;

  always_comb begin
    w_sum = int'(r_count) + int'(i_inc) - int'(i_dec);
    if (w_sum < 0) begin
      w_count_next = '0;
    end else if (w_sum > int'(MaxVal)) begin
      w_count_next = Width'(MaxVal);
    end else begin
      w_count_next = Width'(w_sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= Width'(ResetVal);
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;
  assign o_next  = w_count_next;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues in-order I-memory requests under a buffer
// credit scheme and pushes returned instructions into the instruction buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           INST_WIDTH      = 32,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter int unsigned           BUFFER_DEPTH    = 8,
  parameter int unsigned           MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  buf_write_en,
  output logic [INST_WIDTH-1:0] buf_data_in,
  input  logic                  buf_read_en,
  input  logic                  buf_is_empty,
  output logic                  fetch_fault
);

  localparam int unsigned CreditW = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned OutstW  = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_t          r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
  logic [OutstW-1:0]     r_discard, w_discard_next;
  logic                  r_buf_write_en;
  logic [INST_WIDTH-1:0] r_buf_data_in;

  logic [CreditW-1:0]    w_credit, w_credit_next;
  logic [OutstW-1:0]     w_outst, w_outst_next;
  logic                  w_req_valid, w_hs, w_pop, w_rsp_drop, w_push, w_fault_rsp;
  logic [1:0]            w_credit_inc;
  logic                  w_unused;

  assign w_unused = ^{redirect_pc[1:0], w_credit_next};

  assign w_req_valid = (r_state == RUN) && (w_credit != '0) &&
                       (w_outst < OutstW'(MAX_OUTSTANDING));
  assign w_hs        = w_req_valid && imem_req_ready;
  assign w_pop       = buf_read_en && !buf_is_empty;

  // A response is dropped if stale, arriving with a redirect, in FAULT, or faulting.
  assign w_rsp_drop  = imem_rsp_valid && (redirect_valid || (r_discard != '0) ||
                                          (r_state == FAULT) || imem_rsp_err);
  assign w_push      = imem_rsp_valid && !w_rsp_drop;
  assign w_fault_rsp = imem_rsp_valid && imem_rsp_err && !redirect_valid &&
                       (r_discard == '0) && (r_state != FAULT);

  assign w_credit_inc = {1'b0, w_pop} + {1'b0, w_rsp_drop};

  fetch_credit_counter #(
    .MaxVal   (BUFFER_DEPTH),
    .ResetVal (BUFFER_DEPTH),
    .Width    (CreditW)
  ) u_credit (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_credit_inc),
    .i_dec   (w_hs),
    .o_count (w_credit),
    .o_next  (w_credit_next)
  );

  fetch_credit_counter #(
    .MaxVal   (MAX_OUTSTANDING),
    .ResetVal (0),
    .Width    (OutstW)
  ) u_outstanding (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   ({1'b0, w_hs}),
    .i_dec   (imem_rsp_valid),
    .o_count (w_outst),
    .o_next  (w_outst_next)
  );

  always_comb begin
    w_discard_next = r_discard;
    if (redirect_valid) begin
      w_discard_next = w_outst_next;
    end else if (imem_rsp_valid && (r_discard != '0)) begin
      w_discard_next = r_discard - OutstW'(1);
    end
  end

  always_comb begin
    w_pc_next = r_pc;
    if (redirect_valid) begin
      w_pc_next = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    end else if (w_hs) begin
      w_pc_next = r_pc + ADDR_WIDTH'(INST_BYTES);
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      if (w_discard_next != '0) begin
        w_state_next = DRAIN;
      end else begin
        w_state_next = fetch_enable ? RUN : IDLE;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_fault_rsp)       w_state_next = FAULT;
          else if (fetch_enable) w_state_next = RUN;
        end
        RUN: begin
          if (w_fault_rsp)        w_state_next = FAULT;
          else if (!fetch_enable) w_state_next = IDLE;
        end
        DRAIN: begin
          if (w_discard_next == '0) w_state_next = fetch_enable ? RUN : IDLE;
        end
        FAULT: w_state_next = FAULT;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_pc           <= RESET_PC;
      r_discard      <= '0;
      r_buf_write_en <= 1'b0;
      r_buf_data_in  <= '0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_discard      <= w_discard_next;
      r_buf_write_en <= w_push;
      if (w_push) r_buf_data_in <= imem_rsp_data;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign buf_write_en   = r_buf_write_en;
  assign buf_data_in    = r_buf_data_in;
  assign fetch_fault    = (r_state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: transaction-level model of in-flight requests,
// buffer occupancy and fault/redirect behaviour, checked every cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_enable, redirect_valid, imem_req_ready;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        buf_write_en;
  logic [31:0] buf_data_in;
  logic        buf_read_en, buf_is_empty;
  logic        fetch_fault;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_enable   (fetch_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .buf_write_en   (buf_write_en),
    .buf_data_in    (buf_data_in),
    .buf_read_en    (buf_read_en),
    .buf_is_empty   (buf_is_empty),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        stale;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  // Reference model state
  req_t        inflight[$];
  mem_t        mem_q[$];
  logic [31:0] m_pc;
  logic        m_fault, m_en_q, exp_valid, exp_wr_valid;
  logic [31:0] exp_wr_data;
  int          occ;
  int          cyc;
  int          hs_count, wr_count;
  logic        mem_hs, err_on;
  logic [31:0] mem_addr;

  initial begin
    rst_n = 1'b0; fetch_enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    buf_read_en = 1'b0; buf_is_empty = 1'b1;
    m_pc = 32'h0; m_fault = 1'b0; m_en_q = 1'b0; exp_valid = 1'b0;
    exp_wr_valid = 1'b0; exp_wr_data = '0; occ = 0; cyc = 0;
    hs_count = 0; wr_count = 0; err_on = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_buf_wr_en", 32'(buf_write_en), 32'h0);
    check("rst_buf_data", buf_data_in, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      // Compare DUT outputs against model (negedge, stable)
      check("req_valid", 32'(imem_req_valid), 32'(exp_valid));
      if (exp_valid) check("req_addr", imem_req_addr, m_pc);
      check("buf_wr_en", 32'(buf_write_en), 32'(exp_wr_valid));
      if (exp_wr_valid) check("buf_data", buf_data_in, exp_wr_data);
      check("fault", 32'(fetch_fault), 32'(m_fault));
      check("no_overflow", 32'(buf_write_en && (occ >= 8)), 32'h0);
      if (i == 30) begin
        check("fill_requests", 32'(hs_count), 32'd8);
        check("fill_writes", 32'(wr_count), 32'd8);
      end

      // Stimulus
      fetch_enable = 1'b1; imem_req_ready = 1'b1; buf_read_en = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0; err_on = 1'b0;
      if (i >= 30 && i < 60) begin
        buf_read_en = 1'b1;
      end else if (i >= 60) begin
        fetch_enable   = ($urandom_range(19) != 0);
        imem_req_ready = ($urandom_range(3) != 0);
        buf_read_en    = ($urandom_range(1) == 1);
        err_on         = (i >= 1000 && i < 2000);
        if (i == 60) begin
          redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
        end else if ($urandom_range(39) == 0) begin
          redirect_valid = 1'b1;
          redirect_pc = ($urandom_range(1) == 1) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F))
                                                 : $urandom;
        end
      end
      if (mem_q.size() != 0 && mem_q[0].due == cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(mem_q[0].addr);
        imem_rsp_err   = err_on && ($urandom_range(24) == 0);
      end else begin
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
      end
      buf_is_empty = (occ == 0);
      mem_hs   = imem_req_valid && imem_req_ready;
      mem_addr = imem_req_addr;
      if (i < 30 && mem_hs) hs_count++;
      if (i < 30 && buf_write_en) wr_count++;

      @(posedge clk);
      cyc++;

      // Memory: in-order, fixed latency of two cycles after the handshake
      if (imem_rsp_valid) mem_q.delete(0);
      if (mem_hs) mem_q.push_back('{addr: mem_addr, due: cyc + 2});

      // Model update
      begin
        logic eff_pop, hs, new_wr, stale_any;
        logic [31:0] new_data;
        int n_occ;
        req_t r;
        eff_pop = buf_read_en && (occ != 0);
        hs      = exp_valid && imem_req_ready;
        n_occ   = occ + (exp_wr_valid ? 1 : 0) - (eff_pop ? 1 : 0);
        if (hs) begin
          inflight.push_back('{addr: m_pc, stale: 1'b0});
          m_pc = m_pc + 32'd4;
        end
        new_wr = 1'b0; new_data = '0;
        if (imem_rsp_valid && inflight.size() != 0) begin
          r = inflight.pop_front();
          if (!(r.stale || redirect_valid || m_fault)) begin
            if (imem_rsp_err) m_fault = 1'b1;
            else begin
              new_wr = 1'b1; new_data = mem_data(r.addr);
            end
          end
        end
        if (redirect_valid) begin
          for (int k = 0; k < inflight.size(); k++) inflight[k].stale = 1'b1;
          m_pc = redirect_pc & ~32'h3;
          m_fault = 1'b0;
        end
        exp_wr_valid = new_wr;
        if (new_wr) exp_wr_data = new_data;
        occ    = n_occ;
        m_en_q = fetch_enable;
        stale_any = 1'b0;
        for (int k = 0; k < inflight.size(); k++) if (inflight[k].stale) stale_any = 1'b1;
        exp_valid = m_en_q && !m_fault && !stale_any &&
                    ((occ + (exp_wr_valid ? 1 : 0) + inflight.size()) < 8) &&
                    (inflight.size() < 4);
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
